// File: rtl/pkt_framer_pkg.sv
// Shared widths, flit type encoding and bus payload structs for the packet framer.
package pkt_framer_pkg;

    localparam int unsigned FLIT_WIDTH      = 34;
    localparam int unsigned FLIT_DATA_WIDTH = FLIT_WIDTH - 2;
    localparam int unsigned N_VIRT_CHN      = 2;
    localparam int unsigned VC_W            = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;
    localparam int unsigned PKT_WIDTH       = 8;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10
    } flit_type_t;

    // Raw 2-bit type field so the unencoded 2'b11 value can be carried and detected.
    typedef struct packed {
        logic [1:0]                 ftype;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } flit_t;

    typedef struct packed {
        logic [VC_W-1:0] vc;
        flit_t           flit;
    } noc_word_t;

    typedef struct packed {
        logic [VC_W-1:0]            vc;
        logic                       last;
        logic                       err;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } rx_word_t;

    // Packet size lives in the top bits of a head word's data.
    function automatic logic [PKT_WIDTH-1:0] pkt_size(input logic [FLIT_DATA_WIDTH-1:0] d);
        return d[FLIT_DATA_WIDTH-1 -: PKT_WIDTH];
    endfunction

endpackage

// File: rtl/pkt_framer_if.sv
// AXI-side word streams and router local-port flit streams around the framer.
interface pkt_framer_if;
    import pkt_framer_pkg::*;

    logic                       tx_valid;
    logic                       tx_ready;
    logic [VC_W-1:0]            tx_vc;
    logic [FLIT_DATA_WIDTH-1:0] tx_data;

    logic                       noc_tx_valid;
    logic                       noc_tx_ready;
    logic [FLIT_WIDTH-1:0]      noc_tx_fdata;
    logic [VC_W-1:0]            noc_tx_vc;

    logic                       noc_rx_valid;
    logic                       noc_rx_ready;
    logic [FLIT_WIDTH-1:0]      noc_rx_fdata;
    logic [VC_W-1:0]            noc_rx_vc;

    logic                       rx_valid;
    logic                       rx_ready;
    logic [FLIT_DATA_WIDTH-1:0] rx_data;
    logic [VC_W-1:0]            rx_vc;
    logic                       rx_last;
    logic                       rx_err;

    // Framer side.
    modport slave (
        input  tx_valid, tx_vc, tx_data, noc_tx_ready,
        input  noc_rx_valid, noc_rx_fdata, noc_rx_vc, rx_ready,
        output tx_ready, noc_tx_valid, noc_tx_fdata, noc_tx_vc,
        output noc_rx_ready, rx_valid, rx_data, rx_vc, rx_last, rx_err
    );

    // Environment side (AXI buffers and router).
    modport master (
        output tx_valid, tx_vc, tx_data, noc_tx_ready,
        output noc_rx_valid, noc_rx_fdata, noc_rx_vc, rx_ready,
        input  tx_ready, noc_tx_valid, noc_tx_fdata, noc_tx_vc,
        input  noc_rx_ready, rx_valid, rx_data, rx_vc, rx_last, rx_err
    );

endinterface

// File: rtl/pkt_framer_flit_pipe_reg.sv
// One-entry valid/ready pipeline register; full throughput, output held until accepted.
module pkt_framer_flit_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready_c,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    assign in_ready_c = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pkt_framer.sv
// Frames AXI words into HEAD/BODY/TAIL flits from per-VC size counters and
// framing-checks flits arriving from the router before handing them to AXI.
module pkt_framer
    import pkt_framer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pkt_framer_if.slave           bus,
    output logic [N_VIRT_CHN-1:0] tx_busy,
    output logic [N_VIRT_CHN-1:0] rx_err_sticky,
    input  logic [N_VIRT_CHN-1:0] err_clr
);

    localparam int unsigned TXW = $bits(noc_word_t);
    localparam int unsigned RXW = $bits(rx_word_t);

    logic [PKT_WIDTH-1:0] tx_cnt_q [N_VIRT_CHN];
    logic [PKT_WIDTH-1:0] tx_cnt_d [N_VIRT_CHN];
    logic [PKT_WIDTH-1:0] rx_cnt_q [N_VIRT_CHN];
    logic [PKT_WIDTH-1:0] rx_cnt_d [N_VIRT_CHN];
    logic [N_VIRT_CHN-1:0] sticky_set;

    logic                 tx_accept_c;
    logic [PKT_WIDTH-1:0] tx_cur;
    noc_word_t            tx_word;
    noc_word_t            tx_out;

    logic                 rx_accept_c;
    logic                 rx_pipe_ready_c;
    logic                 rx_drop_c;
    logic                 rx_err_c;
    logic                 rx_last_c;
    logic [PKT_WIDTH-1:0] rx_cur;
    logic [PKT_WIDTH-1:0] rx_nxt;
    logic [PKT_WIDTH-1:0] rx_sz;
    flit_t                rx_in_flit;
    rx_word_t             rx_word;
    rx_word_t             rx_out;

    // TX framing: flit type is decided by how many flits the VC still owes.
    assign tx_accept_c = bus.tx_valid && bus.tx_ready;
    assign tx_cur      = tx_cnt_q[bus.tx_vc];

    always_comb begin
        tx_cnt_d            = tx_cnt_q;
        tx_word             = '0;
        tx_word.vc          = bus.tx_vc;
        tx_word.flit.data   = bus.tx_data;
        tx_word.flit.ftype  = BODY_FLIT;
        if (tx_cur == '0) begin
            tx_word.flit.ftype = HEAD_FLIT;
        end else if (tx_cur == PKT_WIDTH'(1)) begin
            tx_word.flit.ftype = TAIL_FLIT;
        end
        if (tx_accept_c) begin
            if (tx_cur == '0) begin
                tx_cnt_d[bus.tx_vc] = pkt_size(bus.tx_data);
            end else begin
                tx_cnt_d[bus.tx_vc] = tx_cur - PKT_WIDTH'(1);
            end
        end
    end

    pkt_framer_flit_pipe_reg #(.W(TXW)) u_tx_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (bus.tx_valid),
        .in_data    (tx_word),
        .in_ready_c (bus.tx_ready),
        .out_valid  (bus.noc_tx_valid),
        .out_data   (tx_out),
        .out_ready  (bus.noc_tx_ready)
    );

    assign bus.noc_tx_fdata = tx_out.flit;
    assign bus.noc_tx_vc    = tx_out.vc;

    // RX framing check; dropped flits are consumed even when the pipe is full.
    assign rx_in_flit = flit_t'(bus.noc_rx_fdata);
    assign rx_sz      = pkt_size(rx_in_flit.data);
    assign rx_cur     = rx_cnt_q[bus.noc_rx_vc];

    always_comb begin
        rx_drop_c = 1'b0;
        rx_err_c  = 1'b0;
        rx_last_c = 1'b0;
        rx_nxt    = rx_cur;
        if (rx_cur == '0) begin
            if (rx_in_flit.ftype == HEAD_FLIT) begin
                rx_last_c = (rx_sz == '0);
                rx_nxt    = rx_sz;
            end else begin
                rx_drop_c = 1'b1;
                rx_err_c  = 1'b1;
            end
        end else begin
            case (rx_in_flit.ftype)
                HEAD_FLIT: begin
                    rx_err_c  = 1'b1;
                    rx_last_c = (rx_sz == '0);
                    rx_nxt    = rx_sz;
                end
                BODY_FLIT: begin
                    if (rx_cur == PKT_WIDTH'(1)) begin
                        rx_err_c  = 1'b1;
                        rx_last_c = 1'b1;
                        rx_nxt    = '0;
                    end else begin
                        rx_nxt = rx_cur - PKT_WIDTH'(1);
                    end
                end
                TAIL_FLIT: begin
                    rx_err_c  = (rx_cur != PKT_WIDTH'(1));
                    rx_last_c = 1'b1;
                    rx_nxt    = '0;
                end
                default: begin
                    rx_drop_c = 1'b1;
                    rx_err_c  = 1'b1;
                end
            endcase
        end
    end

    assign bus.noc_rx_ready = rx_pipe_ready_c || rx_drop_c;
    assign rx_accept_c      = bus.noc_rx_valid && bus.noc_rx_ready;

    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        sticky_set = '0;
        if (rx_accept_c) begin
            rx_cnt_d[bus.noc_rx_vc]   = rx_nxt;
            sticky_set[bus.noc_rx_vc] = rx_err_c;
        end
    end

    always_comb begin
        rx_word      = '0;
        rx_word.vc   = bus.noc_rx_vc;
        rx_word.last = rx_last_c;
        rx_word.err  = rx_err_c;
        rx_word.data = rx_in_flit.data;
    end

    pkt_framer_flit_pipe_reg #(.W(RXW)) u_rx_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (bus.noc_rx_valid && !rx_drop_c),
        .in_data    (rx_word),
        .in_ready_c (rx_pipe_ready_c),
        .out_valid  (bus.rx_valid),
        .out_data   (rx_out),
        .out_ready  (bus.rx_ready)
    );

    assign bus.rx_data = rx_out.data;
    assign bus.rx_vc   = rx_out.vc;
    assign bus.rx_last = rx_out.last;
    assign bus.rx_err  = rx_out.err;

    always_comb begin
        tx_busy = '0;
        for (int v = 0; v < int'(N_VIRT_CHN); v++) begin
            tx_busy[v] = (tx_cnt_q[v] != '0);
        end
    end

    // Counters and sticky flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < int'(N_VIRT_CHN); v++) begin
                tx_cnt_q[v] <= '0;
                rx_cnt_q[v] <= '0;
            end
            rx_err_sticky <= '0;
        end else begin
            tx_cnt_q      <= tx_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_err_sticky <= (rx_err_sticky & ~err_clr) | sticky_set;
        end
    end

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer with a cycle-level packet model and literal spot checks.
module tb_pkt_framer;
    import pkt_framer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] err_clr = 2'b00;
    logic [1:0] tx_busy;
    logic [1:0] rx_err_sticky;

    pkt_framer_if bus_if ();

    pkt_framer dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if.slave),
        .tx_busy       (tx_busy),
        .rx_err_sticky (rx_err_sticky),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // TX: position inside the current packet and its announced length, per VC.
    int         m_tx_pos [2];
    int         m_tx_len [2];
    bit         m_tx_v;
    logic [33:0] m_tx_f;
    logic       m_tx_vc;
    // RX: flits still owed by the open packet on each VC (0 = no open packet).
    int         m_rx_left [2];
    bit         m_rx_v;
    logic [31:0] m_rx_d;
    logic       m_rx_vc, m_rx_last, m_rx_err;
    logic [1:0] m_sticky;

    function automatic bit rx_drops(input logic [1:0] t, input int left);
        return (left == 0) ? (t != 2'b00) : (t == 2'b11);
    endfunction

    always @(posedge clk) begin : model
        int v, sz;
        logic [1:0] t, set;
        bit drop, rdy, e, l;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_tx_pos[i] = 0; m_tx_len[i] = 0; m_rx_left[i] = 0;
            end
            m_tx_v = 0; m_tx_f = '0; m_tx_vc = 0;
            m_rx_v = 0; m_rx_d = '0; m_rx_vc = 0; m_rx_last = 0; m_rx_err = 0;
            m_sticky = 2'b00;
        end else begin
            if (!m_tx_v || bus_if.noc_tx_ready) begin
                m_tx_v = bus_if.tx_valid;
                if (bus_if.tx_valid) begin
                    v  = int'(bus_if.tx_vc);
                    sz = int'(bus_if.tx_data[31:24]);
                    if (m_tx_pos[v] == 0) begin
                        t = 2'b00; m_tx_len[v] = sz; m_tx_pos[v] = (sz == 0) ? 0 : 1;
                    end else if (m_tx_pos[v] == m_tx_len[v]) begin
                        t = 2'b10; m_tx_pos[v] = 0;
                    end else begin
                        t = 2'b01; m_tx_pos[v] = m_tx_pos[v] + 1;
                    end
                    m_tx_f  = {t, bus_if.tx_data};
                    m_tx_vc = bus_if.tx_vc;
                end
            end
            set  = 2'b00;
            v    = int'(bus_if.noc_rx_vc);
            t    = bus_if.noc_rx_fdata[33:32];
            sz   = int'(bus_if.noc_rx_fdata[31:24]);
            drop = rx_drops(t, m_rx_left[v]);
            rdy  = !m_rx_v || bus_if.rx_ready;
            if (bus_if.noc_rx_valid && (rdy || drop)) begin
                e = 0; l = 0;
                if (m_rx_left[v] == 0) begin
                    if (t == 2'b00) begin l = (sz == 0); m_rx_left[v] = sz; end
                    else e = 1;
                end else begin
                    case (t)
                        2'b00: begin e = 1; l = (sz == 0); m_rx_left[v] = sz; end
                        2'b01: begin
                            if (m_rx_left[v] == 1) begin e = 1; l = 1; m_rx_left[v] = 0; end
                            else m_rx_left[v] = m_rx_left[v] - 1;
                        end
                        2'b10: begin e = (m_rx_left[v] != 1); l = 1; m_rx_left[v] = 0; end
                        default: e = 1;
                    endcase
                end
                set[v] = e;
                if (!drop) begin
                    m_rx_d = bus_if.noc_rx_fdata[31:0]; m_rx_vc = bus_if.noc_rx_vc;
                    m_rx_last = l; m_rx_err = e;
                end
            end
            if (rdy) m_rx_v = bus_if.noc_rx_valid && !drop;
            m_sticky = (m_sticky & ~err_clr) | set;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("noc_tx_valid", 64'(bus_if.noc_tx_valid), 64'(m_tx_v));
            if (m_tx_v) begin
                chk("noc_tx_fdata", 64'(bus_if.noc_tx_fdata), 64'(m_tx_f));
                chk("noc_tx_vc", 64'(bus_if.noc_tx_vc), 64'(m_tx_vc));
            end
            chk("tx_ready", 64'(bus_if.tx_ready), 64'(!m_tx_v || bus_if.noc_tx_ready));
            chk("tx_busy", 64'(tx_busy), 64'({m_tx_pos[1] != 0, m_tx_pos[0] != 0}));
            chk("rx_valid", 64'(bus_if.rx_valid), 64'(m_rx_v));
            if (m_rx_v) begin
                chk("rx_data", 64'(bus_if.rx_data), 64'(m_rx_d));
                chk("rx_vc", 64'(bus_if.rx_vc), 64'(m_rx_vc));
                chk("rx_last", 64'(bus_if.rx_last), 64'(m_rx_last));
                chk("rx_err", 64'(bus_if.rx_err), 64'(m_rx_err));
            end
            chk("noc_rx_ready", 64'(bus_if.noc_rx_ready),
                64'((!m_rx_v || bus_if.rx_ready) ||
                    rx_drops(bus_if.noc_rx_fdata[33:32], m_rx_left[int'(bus_if.noc_rx_vc)])));
            chk("rx_err_sticky", 64'(rx_err_sticky), 64'(m_sticky));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input logic vc, input logic [31:0] d);
        bit acc;
        int n;
        n = 0;
        bus_if.tx_valid = 1'b1; bus_if.tx_vc = vc; bus_if.tx_data = d;
        do begin
            #1; acc = bus_if.tx_ready; step(); n++;
        end while (!acc && n < 50);
        if (!acc) chk("tx_accept_timeout", 64'(0), 64'(1));
        bus_if.tx_valid = 1'b0;
    endtask

    task automatic send_rx(input logic vc, input logic [1:0] t, input logic [31:0] d);
        bit acc;
        int n;
        n = 0;
        bus_if.noc_rx_valid = 1'b1; bus_if.noc_rx_vc = vc; bus_if.noc_rx_fdata = {t, d};
        do begin
            #1; acc = bus_if.noc_rx_ready; step(); n++;
        end while (!acc && n < 50);
        if (!acc) chk("rx_accept_timeout", 64'(0), 64'(1));
        bus_if.noc_rx_valid = 1'b0;
    endtask

    initial begin
        bus_if.tx_valid = 0; bus_if.tx_vc = 0; bus_if.tx_data = '0; bus_if.noc_tx_ready = 0;
        bus_if.noc_rx_valid = 0; bus_if.noc_rx_vc = 0; bus_if.noc_rx_fdata = '0; bus_if.rx_ready = 0;

        // Reset state
        repeat (3) step();
        chk("rst_noc_tx_valid", 64'(bus_if.noc_tx_valid), 64'(0));
        chk("rst_noc_tx_fdata", 64'(bus_if.noc_tx_fdata), 64'(0));
        chk("rst_rx_valid", 64'(bus_if.rx_valid), 64'(0));
        chk("rst_rx_data", 64'(bus_if.rx_data), 64'(0));
        chk("rst_tx_busy", 64'(tx_busy), 64'(0));
        chk("rst_sticky", 64'(rx_err_sticky), 64'(0));
        rst = 1'b0;
        chk_en = 1'b1;
        bus_if.noc_tx_ready = 1'b1;
        bus_if.rx_ready = 1'b1;

        // 1) VC0 head sz=2 then two words
        send_tx(1'b0, 32'h0200_00A1);
        chk("t1_head", 64'({bus_if.noc_tx_vc, bus_if.noc_tx_fdata}), 64'({1'b0, 2'b00, 32'h0200_00A1}));
        chk("t1_busy", 64'(tx_busy), 64'(2'b01));
        send_tx(1'b0, 32'hB0B0_0001);
        chk("t1_body", 64'(bus_if.noc_tx_fdata), 64'({2'b01, 32'hB0B0_0001}));
        send_tx(1'b0, 32'hC0C0_0002);
        chk("t1_tail", 64'(bus_if.noc_tx_fdata), 64'({2'b10, 32'hC0C0_0002}));
        chk("t1_idle", 64'(tx_busy), 64'(2'b00));

        // 2) head-only on VC1, then interleaved VC0/VC1 sz=1 packets
        send_tx(1'b1, 32'h0000_0011);
        chk("t2_head0", 64'({bus_if.noc_tx_vc, bus_if.noc_tx_fdata}), 64'({1'b1, 2'b00, 32'h0000_0011}));
        chk("t2_busy1", 64'(tx_busy), 64'(2'b00));
        send_tx(1'b0, 32'h0100_0020);
        chk("t2_h_vc0", 64'({bus_if.noc_tx_vc, bus_if.noc_tx_fdata}), 64'({1'b0, 2'b00, 32'h0100_0020}));
        send_tx(1'b1, 32'h0100_0021);
        chk("t2_h_vc1", 64'({bus_if.noc_tx_vc, bus_if.noc_tx_fdata}), 64'({1'b1, 2'b00, 32'h0100_0021}));
        chk("t2_busy", 64'(tx_busy), 64'(2'b11));
        send_tx(1'b0, 32'h0000_0030);
        chk("t2_t_vc0", 64'({bus_if.noc_tx_vc, bus_if.noc_tx_fdata}), 64'({1'b0, 2'b10, 32'h0000_0030}));
        send_tx(1'b1, 32'h0000_0031);
        chk("t2_t_vc1", 64'({bus_if.noc_tx_vc, bus_if.noc_tx_fdata}), 64'({1'b1, 2'b10, 32'h0000_0031}));

        // 3) backpressure: flit held 5 cycles, then released exactly once
        send_tx(1'b0, 32'h0100_0033);
        bus_if.noc_tx_ready = 1'b0;
        bus_if.tx_valid = 1'b1; bus_if.tx_vc = 1'b0; bus_if.tx_data = 32'h0000_00DD;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold", 64'(bus_if.noc_tx_fdata), 64'({2'b00, 32'h0100_0033}));
            chk("t3_tx_ready", 64'(bus_if.tx_ready), 64'(0));
        end
        bus_if.noc_tx_ready = 1'b1;
        step();
        bus_if.tx_valid = 1'b0;
        chk("t3_tail", 64'(bus_if.noc_tx_fdata), 64'({2'b10, 32'h0000_00DD}));
        step();
        chk("t3_no_dup", 64'(bus_if.noc_tx_valid), 64'(0));

        // 4) RX HEAD sz=3, BODY, TAIL (tail is early)
        send_rx(1'b0, 2'b00, 32'h0300_0044);
        chk("t4_head", 64'({bus_if.rx_valid, bus_if.rx_last, bus_if.rx_err, bus_if.rx_data}),
            64'({3'b100, 32'h0300_0044}));
        send_rx(1'b0, 2'b01, 32'h0000_0055);
        chk("t4_body", 64'({bus_if.rx_valid, bus_if.rx_last, bus_if.rx_err, bus_if.rx_data}),
            64'({3'b100, 32'h0000_0055}));
        send_rx(1'b0, 2'b10, 32'h0000_0066);
        chk("t4_tail", 64'({bus_if.rx_valid, bus_if.rx_last, bus_if.rx_err, bus_if.rx_data}),
            64'({3'b111, 32'h0000_0066}));
        chk("t4_sticky", 64'(rx_err_sticky), 64'(2'b01));
        send_rx(1'b0, 2'b00, 32'h0000_0045);
        chk("t4_idle", 64'({bus_if.rx_last, bus_if.rx_err}), 64'(2'b10));

        // 5) drops on idle VC1, drop while pipe full, clear vs set
        err_clr = 2'b01; step(); err_clr = 2'b00;
        chk("t5_clr0", 64'(rx_err_sticky), 64'(2'b00));
        send_rx(1'b1, 2'b01, 32'h0000_0077);
        chk("t5_dropped", 64'(bus_if.rx_valid), 64'(0));
        chk("t5_sticky1", 64'(rx_err_sticky), 64'(2'b10));
        bus_if.rx_ready = 1'b0;
        send_rx(1'b0, 2'b00, 32'h0100_0088);
        err_clr = 2'b10;
        bus_if.noc_rx_valid = 1'b1; bus_if.noc_rx_vc = 1'b1; bus_if.noc_rx_fdata = {2'b10, 32'h0000_0099};
        #1;
        chk("t5_drop_ready", 64'(bus_if.noc_rx_ready), 64'(1));
        step();
        bus_if.noc_rx_valid = 1'b0; err_clr = 2'b00;
        chk("t5_set_wins", 64'(rx_err_sticky), 64'(2'b10));
        chk("t5_held", 64'({bus_if.rx_valid, bus_if.rx_data}), 64'({1'b1, 32'h0100_0088}));
        err_clr = 2'b10; step(); err_clr = 2'b00;
        chk("t5_clr1", 64'(rx_err_sticky), 64'(2'b00));
        send_rx(1'b0, 2'b11, 32'h0000_00AA);
        bus_if.rx_ready = 1'b1;
        step();
        chk("t5_rsvd_err", 64'(rx_err_sticky), 64'(2'b01));
        send_rx(1'b0, 2'b10, 32'h0000_00BB);
        chk("t5_tail_ok", 64'({bus_if.rx_last, bus_if.rx_err, bus_if.rx_data}), 64'({2'b10, 32'h0000_00BB}));

        // 6) reset mid-packet, then a fresh packet
        send_tx(1'b0, 32'h0400_0001);
        send_tx(1'b0, 32'h0000_0002);
        send_rx(1'b0, 2'b00, 32'h0400_0003);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_rst_valid", 64'({bus_if.noc_tx_valid, bus_if.rx_valid}), 64'(0));
        chk("t6_rst_busy", 64'(tx_busy), 64'(0));
        send_tx(1'b0, 32'h0100_00E1);
        chk("t6_head", 64'(bus_if.noc_tx_fdata), 64'({2'b00, 32'h0100_00E1}));
        send_tx(1'b0, 32'h0000_00E2);
        chk("t6_tail", 64'(bus_if.noc_tx_fdata), 64'({2'b10, 32'h0000_00E2}));
        send_rx(1'b0, 2'b00, 32'h0000_00F0);
        chk("t6_rx_clean", 64'({bus_if.rx_valid, bus_if.rx_last, bus_if.rx_err}), 64'(3'b110));

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
